// File: rtl/biquad_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// biquad_cfg_sequencer: shadow/active config banks, restart sequencing and
// stuck-bitstream watchdog for the 4-stage biquad sigma-delta filter.
// Revision: 1.0
// ============================================================================
module biquad_cfg_sequencer #(
    parameter int RESET_CYCLES = 4,
    parameter int STALL_LIMIT  = 1024,
    parameter int CNT_W        = 11
) (
    input  logic         filter_clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [3:0]   cfg_addr,
    input  logic [31:0]  cfg_data,
    input  logic         filter_out,
    output logic         filter_reset,
    output logic [159:0] ff_gains,
    output logic [127:0] fb_gains,
    output logic [11:0]  inline_gains,
    output logic [159:0] delay_ivalues,
    output logic         busy,
    output logic         stall_flag,
    output logic [7:0]   stall_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(STALL_LIMIT - 2);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    run_q, run_d;
    logic                prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                flag_q, flag_d;
    logic [7:0]          scnt_q, scnt_d;

    logic [31:0]         shadow_q [0:13];
    logic [31:0]         active_q [0:13];
    logic [11:0]         shadow_inl_q, active_inl_q;

    logic accept, cmd, commit, restart, clr, same, stall;

    assign accept  = cfg_valid && cfg_ready;
    assign cmd     = accept && (cfg_addr == 4'd15);
    assign commit  = cmd && cfg_data[0];
    assign restart = cmd && cfg_data[1];
    assign clr     = cmd && cfg_data[2];
    // run_q counts repeats after the first sample of a run
    assign same    = prev_vld_q && (filter_out == prev_q);
    assign stall   = (state_q == ST_RUN) && same && (run_q == RUN_LAST);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        run_d      = run_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        flag_d     = flag_q;
        scnt_d     = scnt_q;

        if (state_q == ST_HOLD) begin
            run_d      = '0;
            prev_d     = 1'b0;
            prev_vld_d = 1'b0;
            if (hold_q == '0) begin
                state_d = ST_RUN;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end else begin
            prev_d     = filter_out;
            prev_vld_d = 1'b1;
            run_d      = same ? run_q + CNT_W'(1) : '0;
        end

        if (commit || restart || stall) begin
            state_d    = ST_HOLD;
            hold_d     = HOLD_INIT;
            run_d      = '0;
            prev_d     = 1'b0;
            prev_vld_d = 1'b0;
        end

        if (clr) begin
            flag_d = 1'b0;
            scnt_d = 8'd0;
        end
        // a stall on the same edge as a clear still registers
        if (stall) begin
            flag_d = 1'b1;
            scnt_d = (scnt_d == 8'hFF) ? scnt_d : scnt_d + 8'd1;
        end
    end

    always_ff @(posedge filter_clock) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            hold_q     <= HOLD_INIT;
            run_q      <= '0;
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
            flag_q     <= 1'b0;
            scnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            flag_q     <= flag_d;
            scnt_q     <= scnt_d;
        end
    end

    always_ff @(posedge filter_clock) begin
        if (reset) begin
            for (int i = 0; i < 14; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            shadow_inl_q <= '0;
            active_inl_q <= '0;
        end else begin
            if (accept && (cfg_addr <= 4'd13)) begin
                shadow_q[cfg_addr] <= cfg_data;
            end
            if (accept && (cfg_addr == 4'd14)) begin
                shadow_inl_q <= cfg_data[11:0];
            end
            if (commit) begin
                for (int i = 0; i < 14; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                active_inl_q <= shadow_inl_q;
            end
        end
    end

    assign cfg_ready     = (state_q == ST_RUN);
    assign filter_reset  = (state_q == ST_HOLD);
    assign busy          = (state_q == ST_HOLD);
    assign stall_flag    = flag_q;
    assign stall_count   = scnt_q;
    assign ff_gains      = {active_q[4], active_q[3], active_q[2], active_q[1], active_q[0]};
    assign fb_gains      = {active_q[8], active_q[7], active_q[6], active_q[5]};
    assign delay_ivalues = {active_q[13], active_q[12], active_q[11], active_q[10], active_q[9]};
    assign inline_gains  = active_inl_q;

endmodule
`default_nettype wire
